// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes ASCII "Waadd<CR>" / "Raa<CR>" commands arriving
// from the UART receiver into single-cycle register-bus requests, with
// format checking and an inter-byte timeout while a command is open.
module uart_cmd_parser #(
  parameter int CLK_FRE    = 50,
  parameter int TIMEOUT_MS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       reg_wr,
  output logic       reg_rd,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [31:0] TO_CYC  = 32'(CLK_FRE * 1000 * TIMEOUT_MS);
  localparam logic [31:0] TO_LAST = TO_CYC - 32'd1;
  localparam bit          TO_EN   = (TIMEOUT_MS != 0);

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [3:0] {
    S_IDLE, S_W_AH, S_W_AL, S_W_DH, S_W_DL, S_W_EOL,
    S_R_AH, S_R_AL, S_R_EOL, S_DISCARD
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_toCnt;
  logic [7:0]  r_addrBuf;
  logic [7:0]  r_dataBuf;

  logic        w_byte;
  logic        w_isCr;
  logic        w_hexValid;
  logic [3:0]  w_hexNib;
  logic        w_toExpire;
  logic        w_issueWr;
  logic        w_issueRd;
  logic        w_errFmt;
  logic        w_errTo;

  // Returns {valid, nibble} for an ASCII hex digit in either case.
  function automatic logic [4:0] hexDecode(input logic [7:0] c);
    logic [4:0] res;
    res = 5'b0;
    if (c >= 8'h30 && c <= 8'h39)      res = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) res = {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) res = {1'b1, 4'(c - 8'h57)};
    return res;
  endfunction

  // LF never counts as a byte: it neither moves the FSM nor restarts the timeout.
  assign w_byte = rx_valid && (rx_data != CH_LF);
  assign w_isCr = (rx_data == CH_CR);
  assign {w_hexValid, w_hexNib} = hexDecode(rx_data);
  assign w_toExpire = TO_EN && (r_state != S_IDLE) && !w_byte && (r_toCnt == TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state decode; an arriving byte always takes priority over expiry.
  always_comb begin
    w_nextState = r_state;
    w_issueWr   = 1'b0;
    w_issueRd   = 1'b0;
    w_errFmt    = 1'b0;
    w_errTo     = 1'b0;
    if (w_byte) begin
      case (r_state)
        S_IDLE: begin
          if (rx_data == 8'h57 || rx_data == 8'h77)      w_nextState = S_W_AH;
          else if (rx_data == 8'h52 || rx_data == 8'h72) w_nextState = S_R_AH;
          else if (w_isCr)                               w_nextState = S_IDLE;
          else                                           w_nextState = S_DISCARD;
        end
        S_W_AH, S_W_AL, S_W_DH, S_W_DL, S_R_AH, S_R_AL: begin
          if (w_hexValid) begin
            case (r_state)
              S_W_AH:  w_nextState = S_W_AL;
              S_W_AL:  w_nextState = S_W_DH;
              S_W_DH:  w_nextState = S_W_DL;
              S_W_DL:  w_nextState = S_W_EOL;
              S_R_AH:  w_nextState = S_R_AL;
              default: w_nextState = S_R_EOL;
            endcase
          end else if (w_isCr) begin
            w_errFmt    = 1'b1;
            w_nextState = S_IDLE;
          end else begin
            w_nextState = S_DISCARD;
          end
        end
        S_W_EOL: begin
          if (w_isCr) begin
            w_issueWr   = 1'b1;
            w_nextState = S_IDLE;
          end else begin
            w_nextState = S_DISCARD;
          end
        end
        S_R_EOL: begin
          if (w_isCr) begin
            w_issueRd   = 1'b1;
            w_nextState = S_IDLE;
          end else begin
            w_nextState = S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (w_isCr) begin
            w_errFmt    = 1'b1;
            w_nextState = S_IDLE;
          end
        end
        default: w_nextState = S_IDLE;
      endcase
    end else if (w_toExpire) begin
      w_errTo     = 1'b1;
      w_nextState = S_IDLE;
    end
  end

  // Inter-byte timeout counter: parked at zero in IDLE, cleared by every real byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            r_toCnt <= 32'd0;
    else if (!TO_EN || w_byte || r_state == S_IDLE || w_toExpire) r_toCnt <= 32'd0;
    else                                                   r_toCnt <= r_toCnt + 32'd1;
  end

  // Assemble address/data nibbles privately so the bus never sees partial values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addrBuf <= 8'h00;
      r_dataBuf <= 8'h00;
    end else if (w_byte && w_hexValid) begin
      case (r_state)
        S_W_AH, S_W_AL, S_R_AH, S_R_AL: r_addrBuf <= {r_addrBuf[3:0], w_hexNib};
        S_W_DH, S_W_DL:                 r_dataBuf <= {r_dataBuf[3:0], w_hexNib};
        default: ;
      endcase
    end
  end

  // Registered outputs: single-cycle pulses, held bus values and error code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      err       <= 1'b0;
      err_code  <= 2'b00;
      busy      <= 1'b0;
    end else begin
      reg_wr <= w_issueWr;
      reg_rd <= w_issueRd;
      err    <= w_errFmt || w_errTo;
      busy   <= (w_nextState != S_IDLE);
      if (w_issueWr) begin
        reg_addr  <= r_addrBuf;
        reg_wdata <= r_dataBuf;
      end else if (w_issueRd) begin
        reg_addr  <= r_addrBuf;
      end
      if (w_errFmt)     err_code <= 2'b01;
      else if (w_errTo) err_code <= 2'b10;
    end
  end

endmodule
